// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
// Single-cycle AND/OR/XOR/ADD/SUB and a WIDTH-step shift-add multiply.
// One operation is in flight at a time; the result is held until the consumer takes it.
`timescale 1ns/1ps
module alu_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   In1,
   input  logic [WIDTH-1:0]   In2,
   input  logic [2:0]         Sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] Out,
   output logic               flag_zero,
   output logic               flag_carry,
   output logic               flag_err
);

   localparam int unsigned OutW = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [OutW-1:0]   out_q, out_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;
   logic              err_q, err_d;
   logic [OutW-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [OutW-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Single-cycle op results, all widened to the output width.
   logic [WIDTH:0]    sum_w;
   logic [WIDTH:0]    diff_w;
   logic [OutW-1:0]   op_res;
   logic              op_err;
   // Accumulator value after the current multiply step.
   logic [OutW-1:0]   acc_next;

   // Decode the single-cycle operation from the presented operands.
   always_comb begin
      sum_w  = {1'b0, In1} + {1'b0, In2};
      diff_w = {1'b0, In1} - {1'b0, In2};
      op_res = '0;
      op_err = 1'b0;
      case (Sel)
         3'd0:    op_res = {{WIDTH{1'b0}}, In1 & In2};
         3'd1:    op_res = {{WIDTH{1'b0}}, In1 | In2};
         3'd2:    op_res = {{WIDTH{1'b0}}, In1 ^ In2};
         3'd3:    op_res = {{(WIDTH-1){1'b0}}, sum_w};
         3'd4:    op_res = {{(WIDTH-1){1'b0}}, diff_w};
         3'd5:    op_res = '0;
         default: begin
            op_res = '0;
            op_err = 1'b1;
         end
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
   always_comb begin
      acc_next = acc_q;
      if (mplier_q[0]) begin
         acc_next = acc_q + mcand_q;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      err_d    = err_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (Sel == 3'd5) begin
                  mcand_d  = {{WIDTH{1'b0}}, In1};
                  mplier_d = In2;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = StMul;
               end else begin
                  out_d   = op_res;
                  zero_d  = (op_res == '0);
                  // Carry/borrow only means something for ADD and SUB.
                  carry_d = ((Sel == 3'd3) || (Sel == 3'd4)) ? op_res[WIDTH] : 1'b0;
                  err_d   = op_err;
                  state_d = StDone;
               end
            end
         end
         StMul: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastStep) begin
               out_d   = acc_next;
               zero_d  = (acc_next == '0);
               carry_d = 1'b0;
               err_d   = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            // Result stays put until the consumer takes it.
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         out_q    <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   // Handshake signals come straight from the state; result and flags from registers.
   always_comb begin
      in_ready   = (state_q == StIdle);
      out_valid  = (state_q == StDone);
      Out        = out_q;
      flag_zero  = zero_q;
      flag_carry = carry_q;
      flag_err   = err_q;
   end

endmodule
